vp_key_event_queue: RTL
=======================

VP_KEY_EVENT_QUEUE -- requirements
Module: vp_key_event_queue

Interface
REQ-001 Parameter NUM_PADS, default 2: number of joystick numpad sources, range 1..4.
REQ-002 Parameter DEPTH, default 8: event FIFO entries, a power of two, range 4..64.
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ps2_key  in  11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] scan code.
REQ-006 joy_numpad_i  in  10*NUM_PADS  pad p numpad keys at bits [10p+9:10p], 1 = pressed, bit k = key k.
REQ-007 evt_valid_o  out  1  FIFO head holds an event.
REQ-008 evt_ascii_o  out  8  head event ASCII code.
REQ-009 evt_released_o  out  1  head event is a release.
REQ-010 evt_ready_i  in  1  consumer accepts the head event.
REQ-011 overflow_o  out  1  sticky: a PS/2 event was dropped.
REQ-012 level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 The block SHALL detect a PS/2 event when ps2_key[10] differs from its value registered on the previous cycle.
REQ-014 PS/2 mapping SHALL ignore ps2_key[8] and translate scan codes as follows: 16,1E,26,25,2E,36,3D,3E,46,45 map to "1".."9","0"; letters map per the standard set-2 table to "a".."z"; 29 maps to " "; 79 "+", 7B "-", 7C "*", 4A "/", 55 "="; 1F 0x11; 27 0x12; 5A 0x0A; 66 0x08.
REQ-015 Unmapped scan codes SHALL generate no event.
REQ-016 PS/2 events SHALL carry released = ~ps2_key[9].
REQ-017 The joystick key vector SHALL be the bitwise OR of all NUM_PADS pad slices, registered once per cycle.
REQ-018 Any change in key k of the joystick key vector SHALL set pend[k] and record pend_rel[k] = ~new_state.
REQ-019 A further change of key k while pend[k] is set SHALL overwrite pend_rel[k]; only the latest state is enqueued.
REQ-020 Joystick key k SHALL map to ASCII "1".."9" for k = 0..8 and to "0" for k = 9.
REQ-021 At most one event SHALL be pushed per cycle; a PS/2 event has priority over joystick events.
REQ-022 With no PS/2 event that cycle, the block SHALL push the lowest-index pending joystick key and clear its pend bit, provided the FIFO is not full.
REQ-023 A PS/2 event arriving while the FIFO is full and no pop occurs that cycle SHALL be dropped and SHALL set overflow_o.
REQ-024 Pending joystick events SHALL never be dropped; they wait until the FIFO has space.
REQ-025 The FIFO SHALL be first-word-fall-through: evt_valid_o = (level_o != 0), and outputs reflect the head event combinationally from registered storage.
REQ-026 A pop SHALL occur on a cycle with evt_valid_o & evt_ready_i.
REQ-027 A push and a pop in the same cycle SHALL both be performed, including when the FIFO is full, leaving level_o unchanged.
REQ-028 A pushed event SHALL appear at the head no earlier than the cycle after the push; latency from ps2_key toggle to evt_valid_o with an empty FIFO is 2 cycles.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 overflow_o SHALL clear only on reset.

Reset
REQ-031 On reset, level_o = 0, evt_valid_o = 0, evt_ascii_o = 0x00, evt_released_o = 0, overflow_o = 0, pointers = 0, and pend = 0.
REQ-032 On reset, the registered ps2_key[10] SHALL be loaded from the input, so no spurious PS/2 event occurs after reset.
REQ-033 On reset, the registered joystick vector SHALL be loaded from the input, so keys held through reset produce no event.
REQ-034 Reset mid-operation SHALL discard all queued and pending events.

Configuration
REQ-035 With macro VP_KEYQ_JOY_EN defined, the joystick path (REQ-017..REQ-020, REQ-022, REQ-024) SHALL be present.
REQ-036 With VP_KEYQ_JOY_EN undefined, joy_numpad_i SHALL be ignored, no pend logic SHALL be synthesised, and only PS/2 events SHALL be queued.

Verification
REQ-037 Empty FIFO, toggle ps2_key with code 0x16 pressed -> 2 cycles later evt_valid_o=1, evt_ascii_o=0x31, evt_released_o=0; pulse evt_ready_i -> level_o=0.
REQ-038 evt_ready_i=0, send DEPTH+1 PS/2 key 0x1C events -> level_o=DEPTH, overflow_o=1, head still "a".
REQ-039 Pad0 key 2 and pad1 key 5 pressed on the same cycle -> events "3" then "6" in order, both released=0; releasing pad0 key 2 while pad1 key 2 is held -> no event.
REQ-040 FIFO full, PS/2 event coincident with a pop -> event accepted, level_o stays DEPTH, overflow_o stays 0.
REQ-041 Joystick key 9 pressed and released while the FIFO is full -> after one pop, a single event "0" with released=1 is enqueued.
REQ-042 Reset asserted with 3 queued events and key 0 held -> level_o=0; after reset, no event occurs until key 0 changes.

Source files
------------

// File: rtl/vp_key_event_queue.sv
// vp_key_event_queue: merges PS/2 key events and joystick numpad key changes
// into one first-word-fall-through event FIFO of {released, ascii} entries.
// Optional joystick path is compiled in with macro VP_KEYQ_JOY_EN; without it
// only PS/2 events are queued and joy_numpad_i is ignored.
module vp_key_event_queue #(
  parameter int NUM_PADS = 2,
  parameter int DEPTH    = 8
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [10:0]               ps2_key,
  input  logic [10*NUM_PADS-1:0]    joy_numpad_i,
  output logic                      evt_valid_o,
  output logic [7:0]                evt_ascii_o,
  output logic                      evt_released_o,
  input  logic                      evt_ready_i,
  output logic                      overflow_o,
  output logic [$clog2(DEPTH):0]    level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  // Set-2 scan code to ASCII; bit 8 flags a mapped code.
  function automatic logic [8:0] ps2_map(input logic [7:0] code);
    logic [8:0] m;
    case (code)
      8'h16: m = {1'b1, 8'h31};  8'h1E: m = {1'b1, 8'h32};
      8'h26: m = {1'b1, 8'h33};  8'h25: m = {1'b1, 8'h34};
      8'h2E: m = {1'b1, 8'h35};  8'h36: m = {1'b1, 8'h36};
      8'h3D: m = {1'b1, 8'h37};  8'h3E: m = {1'b1, 8'h38};
      8'h46: m = {1'b1, 8'h39};  8'h45: m = {1'b1, 8'h30};
      8'h1C: m = {1'b1, 8'h61};  8'h32: m = {1'b1, 8'h62};
      8'h21: m = {1'b1, 8'h63};  8'h23: m = {1'b1, 8'h64};
      8'h24: m = {1'b1, 8'h65};  8'h2B: m = {1'b1, 8'h66};
      8'h34: m = {1'b1, 8'h67};  8'h33: m = {1'b1, 8'h68};
      8'h43: m = {1'b1, 8'h69};  8'h3B: m = {1'b1, 8'h6A};
      8'h42: m = {1'b1, 8'h6B};  8'h4B: m = {1'b1, 8'h6C};
      8'h3A: m = {1'b1, 8'h6D};  8'h31: m = {1'b1, 8'h6E};
      8'h44: m = {1'b1, 8'h6F};  8'h4D: m = {1'b1, 8'h70};
      8'h15: m = {1'b1, 8'h71};  8'h2D: m = {1'b1, 8'h72};
      8'h1B: m = {1'b1, 8'h73};  8'h2C: m = {1'b1, 8'h74};
      8'h3C: m = {1'b1, 8'h75};  8'h2A: m = {1'b1, 8'h76};
      8'h1D: m = {1'b1, 8'h77};  8'h22: m = {1'b1, 8'h78};
      8'h35: m = {1'b1, 8'h79};  8'h1A: m = {1'b1, 8'h7A};
      8'h29: m = {1'b1, 8'h20};  8'h79: m = {1'b1, 8'h2B};
      8'h7B: m = {1'b1, 8'h2D};  8'h7C: m = {1'b1, 8'h2A};
      8'h4A: m = {1'b1, 8'h2F};  8'h55: m = {1'b1, 8'h3D};
      8'h1F: m = {1'b1, 8'h11};  8'h27: m = {1'b1, 8'h12};
      8'h5A: m = {1'b1, 8'h0A};  8'h66: m = {1'b1, 8'h08};
      default: m = 9'h000;
    endcase
    return m;
  endfunction

  // PS/2 input stage and toggle history
  logic [10:0] ps2_q;
  logic        tog_q;
  logic [8:0]  ps2_m;
  logic        ps2_evt;

  // FIFO state
  logic [8:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q;
  logic          ovf_q;
  logic          full, pop, push;
  logic [8:0]    push_data;
  logic          joy_push;
  logic [8:0]    joy_data;

  assign ps2_m   = ps2_map(ps2_q[7:0]);
  assign ps2_evt = (ps2_q[10] ^ tog_q) & ps2_m[8];
  assign full    = (level_q == LVL_FULL);
  assign pop     = evt_valid_o & evt_ready_i;

  // Register the PS/2 word, then remember the previous toggle; reset loads
  // both from the live input so no event appears after reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ps2_q <= ps2_key;
      tog_q <= ps2_key[10];
    end else begin
      ps2_q <= ps2_key;
      tog_q <= ps2_q[10];
    end
  end

`ifdef VP_KEYQ_JOY_EN
  logic [9:0] joy_acc [0:NUM_PADS];
  logic [9:0] joy_or, joy_q, pend_q, pend_rel_q, joy_chg, joy_clr;
  logic [3:0] joy_sel;
  logic       joy_any;

  assign joy_acc[0] = 10'd0;
  for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad_or
    assign joy_acc[gi+1] = joy_acc[gi] | joy_numpad_i[10*gi +: 10];
  end
  assign joy_or  = joy_acc[NUM_PADS];
  assign joy_chg = joy_or ^ joy_q;

  // Pick the lowest-index pending key.
  always_comb begin
    joy_sel = 4'd0;
    joy_any = 1'b0;
    for (int k = 9; k >= 0; k--) begin
      if (pend_q[k]) begin
        joy_sel = 4'(k);
        joy_any = 1'b1;
      end
    end
  end

  // Joystick pushes only into a non-full FIFO and only when PS/2 is idle.
  assign joy_push = joy_any & ~ps2_evt & ~full;
  assign joy_clr  = joy_push ? (10'd1 << joy_sel) : 10'd0;
  assign joy_data = {pend_rel_q[joy_sel],
                     (joy_sel == 4'd9) ? 8'h30 : (8'h31 + {4'd0, joy_sel})};

  // Track key vector and pending changes; a fresh change re-arms the bit
  // even if it is being pushed this cycle, keeping only the newest state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      joy_q      <= joy_or;
      pend_q     <= 10'd0;
      pend_rel_q <= 10'd0;
    end else begin
      joy_q      <= joy_or;
      pend_q     <= (pend_q & ~joy_clr) | joy_chg;
      pend_rel_q <= (pend_rel_q & ~joy_chg) | (~joy_or & joy_chg);
    end
  end
`else
  logic unused_joy;
  assign unused_joy = ^joy_numpad_i;
  assign joy_push   = 1'b0;
  assign joy_data   = 9'd0;
`endif

  // Select the single push source for this cycle; PS/2 wins.
  always_comb begin
    push      = 1'b0;
    push_data = joy_data;
    if (ps2_evt) begin
      push      = ~full | pop;
      push_data = {~ps2_q[9], ps2_m[7:0]};
    end else if (joy_push) begin
      push      = 1'b1;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk_sys) begin
    if (push && !reset) mem[wptr_q] <= push_data;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
      if (ps2_evt && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign evt_valid_o    = (level_q != '0);
  assign evt_ascii_o    = evt_valid_o ? mem[rptr_q][7:0] : 8'h00;
  assign evt_released_o = evt_valid_o & mem[rptr_q][8];
  assign overflow_o     = ovf_q;
  assign level_o        = level_q;

endmodule
